// File: rtl/piccolo_pkg.sv
// rtl/piccolo_pkg.sv - state encoding and byte-count constants for the Piccolo input loader
package piccolo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_KEY   = 3'd1,
        ST_PT    = 3'd2,
        ST_START = 3'd3,
        ST_WAIT  = 3'd4
    } state_e;

    localparam int KEY_BYTES_80  = 10;
    localparam int KEY_BYTES_128 = 16;
    localparam int PT_BYTES      = 8;

    localparam logic [4:0] KEY_LAST_80  = 5'd9;
    localparam logic [4:0] KEY_LAST_128 = 5'd15;
    localparam logic [4:0] PT_LAST      = 5'd7;

    function automatic logic [4:0] key_last(input logic version);
        return version ? KEY_LAST_128 : KEY_LAST_80;
    endfunction

endpackage

// File: rtl/piccolo_in_loader.sv
// rtl/piccolo_in_loader.sv - byte-serial key/plaintext loader for the Piccolo core
// Optional key reuse across frames is enabled by defining PICCOLO_KEY_CACHE_EN.
module piccolo_in_loader
    import piccolo_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [7:0]     in_data,
    input  logic           in_version,
    input  logic           in_key_skip,
    output logic           core_start,
    output logic [0:63]    core_pt,
    output logic [0:127]   core_key,
    output logic           core_version,
    input  logic           core_done,
    output logic           busy
);

    state_e        state_q, state_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [0:63]   pt_q, pt_d;
    logic [0:127]  key_q, key_d;
    logic          ver_q, ver_d;
    logic          xfer;
    logic          skip;
    logic [6:0]    key_idx;
    logic [5:0]    pt_idx;

`ifdef PICCOLO_KEY_CACHE_EN
    logic key_valid_q, key_valid_d;
    logic key_ver_q, key_ver_d;

    assign skip = in_key_skip && key_valid_q && (in_version == key_ver_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            key_valid_q <= 1'b0;
            key_ver_q   <= 1'b0;
        end else begin
            key_valid_q <= key_valid_d;
            key_ver_q   <= key_ver_d;
        end
    end
`else
    logic unused_key_skip;
    assign unused_key_skip = in_key_skip;
    assign skip = 1'b0;
`endif

    assign xfer    = in_valid && in_ready;
    assign key_idx = {cnt_q[3:0], 3'b000};
    assign pt_idx  = {cnt_q[2:0], 3'b000};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (xfer) state_d = skip ? ST_PT : ST_KEY;
            ST_KEY:   if (xfer && cnt_q == key_last(ver_q)) state_d = ST_PT;
            ST_PT:    if (xfer && cnt_q == PT_LAST) state_d = ST_START;
            ST_START: state_d = ST_WAIT;
            ST_WAIT:  if (core_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // in_ready is forced low while reset is held so no byte slips in during reset.
    always_comb begin
        in_ready   = !reset && (state_q == ST_IDLE || state_q == ST_KEY || state_q == ST_PT);
        core_start = (state_q == ST_START);
        busy       = (state_q == ST_START || state_q == ST_WAIT);
    end

    always_comb begin
        cnt_d = cnt_q;
        pt_d  = pt_q;
        key_d = key_q;
        ver_d = ver_q;
`ifdef PICCOLO_KEY_CACHE_EN
        key_valid_d = key_valid_q;
        key_ver_d   = key_ver_q;
`endif
        if (xfer) begin
            case (state_q)
                ST_IDLE: begin
                    ver_d = in_version;
                    cnt_d = 5'd1;
                    if (skip) begin
                        pt_d[0:7] = in_data;
                    end else begin
                        key_d      = '0;
                        key_d[0:7] = in_data;
                    end
                end
                ST_KEY: begin
                    key_d[key_idx +: 8] = in_data;
                    if (cnt_q == key_last(ver_q)) begin
                        cnt_d = 5'd0;
`ifdef PICCOLO_KEY_CACHE_EN
                        key_valid_d = 1'b1;
                        key_ver_d   = ver_q;
`endif
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                ST_PT: begin
                    pt_d[pt_idx +: 8] = in_data;
                    cnt_d = (cnt_q == PT_LAST) ? 5'd0 : cnt_q + 5'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            pt_q  <= '0;
            key_q <= '0;
            ver_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pt_q  <= pt_d;
            key_q <= key_d;
            ver_q <= ver_d;
        end
    end

    assign core_pt      = pt_q;
    assign core_key     = key_q;
    assign core_version = ver_q;

endmodule

// File: tb/tb_piccolo_in_loader.sv
// tb/tb_piccolo_in_loader.sv - scoreboard bench for piccolo_in_loader with a frame-level reference model
module tb_piccolo_in_loader;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [7:0]     in_data;
    logic           in_version;
    logic           in_key_skip;
    logic           core_start;
    logic [0:63]    core_pt;
    logic [0:127]   core_key;
    logic           core_version;
    logic           core_done;
    logic           busy;

    piccolo_in_loader dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_version   (in_version),
        .in_key_skip  (in_key_skip),
        .core_start   (core_start),
        .core_pt      (core_pt),
        .core_key     (core_key),
        .core_version (core_version),
        .core_done    (core_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int n_assert = 0;
    int n_fail   = 0;
    int frames   = 0;
    int starts   = 0;
    int last_acc = 0;
    int done_cyc = -100;

    logic [192:0] exp_q[$];
    int           delay_q[$];

    logic         m_valid = 1'b0;
    logic         m_ver   = 1'b0;
    logic [127:0] m_key   = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic abort(input string name);
        n_fail++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $fatal(1);
    endtask

    // Offer one byte and hold it until the loader takes it; returns the acceptance cycle.
    task automatic send_byte(input logic [7:0] b, input logic ver, input logic skip,
                             input int gap_pct, output int acc);
        int budget;
        if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        in_valid    = 1'b1;
        in_data     = b;
        in_version  = ver;
        in_key_skip = skip;
        budget      = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            budget++;
            if (budget > 300) abort("send_byte_ready");
        end
        @(posedge clk);
        acc = cycle;
        #1;
    endtask

    task automatic send_frame(input logic ver, input logic skip, input logic [127:0] key,
                              input logic [63:0] pt, input int gap_pct, input int delay,
                              input logic check_turn);
        logic         use_skip;
        logic [127:0] ek;
        int           nk, acc, first_acc;
        nk = ver ? 16 : 10;
`ifdef PICCOLO_KEY_CACHE_EN
        use_skip = skip && m_valid && (m_ver == ver);
`else
        use_skip = 1'b0;
`endif
        if (use_skip) ek = m_key;
        else          ek = ver ? key : {key[127:48], 48'h0};
        exp_q.push_back({ek, pt, ver});
        delay_q.push_back(delay);
        frames++;
        first_acc = -1;
        if (!use_skip) begin
            for (int i = 0; i < nk; i++) begin
                send_byte(key[127-8*i -: 8], ver, skip, gap_pct, acc);
                if (i == 0) first_acc = acc;
            end
            m_valid = 1'b1;
            m_ver   = ver;
            m_key   = ek;
        end
        for (int i = 0; i < 8; i++) begin
            send_byte(pt[63-8*i -: 8], ver, skip, gap_pct, acc);
            if (first_acc < 0) first_acc = acc;
        end
        last_acc = acc;
        in_valid = 1'b0;
        if (check_turn) chk("turnaround_first_byte", 128'(first_acc), 128'(done_cyc + 1));
    endtask

    // Core stand-in: after each start, hold done low for the frame's delay, then pulse it.
    initial begin
        int d;
        core_done = 1'b0;
        forever begin
            @(negedge clk);
            if (core_start && delay_q.size() > 0) begin
                d = delay_q.pop_front();
                repeat (d) @(posedge clk);
                #1 core_done = 1'b1;
                @(posedge clk);
                #1 core_done = 1'b0;
            end
        end
    end

    // Monitor: pop an expected frame on each start and check outputs stay frozen while busy.
    initial begin
        logic [192:0] e;
        logic         have;
        have = 1'b0;
        e    = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                have = 1'b0;
                continue;
            end
            if (core_start) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_start", 128'(core_start), 128'(0));
                end else begin
                    e    = exp_q.pop_front();
                    have = 1'b1;
                    starts++;
                    chk("core_key",      core_key,           e[192:65]);
                    chk("core_pt",       128'(core_pt),      128'(e[64:1]));
                    chk("core_version",  128'(core_version), 128'(e[0]));
                    chk("busy_at_start", 128'(busy),         128'(1));
                    chk("start_latency", 128'(cycle),        128'(last_acc + 1));
                end
            end else if (busy) begin
                chk("in_ready_wait", 128'(in_ready), 128'(0));
                if (have) begin
                    chk("key_stable", core_key, e[192:65]);
                    chk("pt_stable",  128'(core_pt), 128'(e[64:1]));
                end
                if (core_done) done_cyc = cycle;
            end
        end
    end

    localparam logic [127:0] KEY128 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY80  = {80'h00112233445566778899, 48'h0};
    localparam logic [63:0]  PT_A   = 64'h0123456789abcdef;
    localparam logic [63:0]  PT_B   = 64'hfedcba9876543210;

    initial begin
        int acc, budget;
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        in_version  = 1'b0;
        in_key_skip = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready",   128'(in_ready),   128'(0));
        chk("reset_core_start", 128'(core_start), 128'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 128'(in_ready),     128'(1));
        chk("idle_busy",     128'(busy),         128'(0));
        chk("idle_key",      core_key,           128'(0));
        chk("idle_pt",       128'(core_pt),      128'(0));
        chk("idle_version",  128'(core_version), 128'(0));
        @(posedge clk);
        #1;

        send_frame(1'b1, 1'b0, KEY128, PT_A, 0, 3, 1'b0);
        send_frame(1'b0, 1'b0, KEY80,  PT_A, 0, 2, 1'b0);
        send_frame(1'b1, 1'b0, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}, 0, 30, 1'b0);
        send_frame(1'b0, 1'b0, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}, 0, 2, 1'b1);
        send_frame(1'b1, 1'b0, KEY128, PT_A, 50, 4, 1'b0);

        for (int i = 0; i < 12; i++) send_byte(8'(8'hA0 + i), 1'b1, 1'b0, 0, acc);
        in_valid = 1'b0;
        reset    = 1'b1;
        m_valid  = 1'b0;
        @(negedge clk);
        chk("midframe_reset_in_ready", 128'(in_ready), 128'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("after_reset_key", core_key, 128'(0));
        @(posedge clk);
        #1;
        send_frame(1'b0, 1'b0, KEY80, PT_A, 0, 2, 1'b0);

        send_frame(1'b1, 1'b0, KEY128, PT_A, 0, 2, 1'b0);
        send_frame(1'b1, 1'b1, 128'h0, PT_B, 0, 2, 1'b0);
        send_frame(1'b0, 1'b1, KEY80,  PT_B, 0, 2, 1'b0);

        for (int i = 0; i < 8; i++) begin
            send_frame(1'($urandom_range(1)), 1'($urandom_range(1)),
                       {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom},
                       30, $urandom_range(1, 6), 1'b0);
        end

        budget = 0;
        while ((exp_q.size() != 0 || busy) && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        chk("drain_timeout", 128'(budget < 500), 128'(1));
        chk("start_count",   128'(starts),       128'(frames));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
